ifu_fetch_ctrl: RTL and testbench

//  Consumer side of the PC register: reads the fetch PC, issues in-order requests to the I-cache,
//  and pulses fetch_adv so the PC register advances.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/ifu_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and defaults for the instruction fetch unit.
//   fetch_entry_t : {pc, inst} pair buffered toward decode
//   ifu_state_e   : fetch controller FSM states
//   IFU_FIFO_DEP  : default instruction FIFO depth / outstanding-request limit
package ifu_pkg;

   localparam int unsigned IFU_PC_W     = 32;
   localparam int unsigned IFU_INST_W   = 32;
   localparam int unsigned IFU_FIFO_DEP = 2;

   typedef struct packed {
      logic [IFU_PC_W-1:0]   pc;
      logic [IFU_INST_W-1:0] inst;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: generic synchronous FIFO with a synchronous flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clears the FIFO at the next edge (wins over push/pop)
//   push, wdata    : write request / data (ignored when full unless popping too)
//   pop, rdata     : read request (ignored when empty) / head data (valid when !empty)
//   empty, full    : status
//   count          : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ifu_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic [31:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  T                           wdata,
   input  logic                       pop,
   output T                           rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   T               mem [DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [CW-1:0]  count_q;
   logic           do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem[rptr_q];
   assign do_pop  = pop & ~empty;
   // A push at full is legal when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: contents are only visible while count_q > 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch controller between the PC register, the I-cache front port and decode.
//   clk, rst_n            : clock, asynchronous active-low reset
//   fetch_pc / fetch_adv  : PC register output / advance pulse (one per accepted request)
//   ic_req/ic_addr/ic_gnt : I-cache request handshake (ic_addr = fetch_pc)
//   ic_rvalid/ic_rdata    : in-order I-cache responses, unbounded latency
//   id_valid/id_inst/id_pc/id_ready : buffered instruction stream toward decode
//   flush                 : redirect; kills buffered and in-flight fetches
// Optional (macro IFU_PERF_CNT_EN): perf_fetch_cnt, perf_stall_cnt saturating 32-bit counters.
module ifu_fetch_ctrl
   import ifu_pkg::*;
#(
   parameter int unsigned PC_W     = IFU_PC_W,
   parameter int unsigned INST_W   = IFU_INST_W,
   parameter int unsigned FIFO_DEP = IFU_FIFO_DEP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              fetch_adv,
   output logic              ic_req,
   output logic [PC_W-1:0]   ic_addr,
   input  logic              ic_gnt,
   input  logic              ic_rvalid,
   input  logic [INST_W-1:0] ic_rdata,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc,
   input  logic              id_ready,
   input  logic              flush
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEP) + 1;

   ifu_state_e    state_q, state_d;
   logic [CW-1:0] out_q, out_d;     // requests accepted but not yet answered
   logic [CW-1:0] drop_q, drop_d;   // responses still to discard after a flush
   logic [CW:0]   credit_used;
   logic          accept, resp_keep, id_pop;

   logic [CW-1:0] fifo_count, tag_count;
   logic          fifo_empty, fifo_full, tag_empty, tag_full;
   logic [PC_W-1:0] tag_head;
   fetch_entry_t  entry_in, entry_out;

   // Credit covers both buffered and in-flight instructions, so a response always has a slot.
   assign credit_used = (CW+1)'(out_q) + (CW+1)'(fifo_count);
   assign ic_req      = (state_q == RUN) & ~flush & (credit_used < (CW+1)'(FIFO_DEP));
   assign ic_addr     = fetch_pc;
   assign accept      = ic_req & ic_gnt;
   assign fetch_adv   = accept;
   assign out_d       = out_q + CW'(accept) - CW'(ic_rvalid);
   // A response in the flush cycle belongs to the killed path and is dropped.
   assign resp_keep   = (state_q == RUN) & ic_rvalid & ~flush;

   assign id_valid    = ~fifo_empty;
   assign id_pop      = id_valid & id_ready;
   assign id_inst     = entry_out.inst;
   assign id_pc       = entry_out.pc;

   always_comb begin
      entry_in      = '0;
      entry_in.pc   = tag_head;
      entry_in.inst = ic_rdata;
   end

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (flush) begin
               drop_d = out_d;
               if (out_d != '0) state_d = DRAIN;
            end
         end
         DRAIN: begin
            drop_d = flush ? out_d : (drop_q - CW'(ic_rvalid));
            if (drop_d == '0) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   // PCs of in-flight requests, matched to responses in order.
   ifu_fifo #(
      .DEPTH (FIFO_DEP),
      .T     (logic [PC_W-1:0])
   ) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (accept),
      .wdata (fetch_pc),
      .pop   (resp_keep),
      .rdata (tag_head),
      .empty (tag_empty),
      .full  (tag_full),
      .count (tag_count)
   );

   ifu_fifo #(
      .DEPTH (FIFO_DEP),
      .T     (fetch_entry_t)
   ) u_inst_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (resp_keep),
      .wdata (entry_in),
      .pop   (id_pop),
      .rdata (entry_out),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (accept && perf_fetch_q != '1) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (state_q == RUN && !accept && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

`ifndef SYNTHESIS
   a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      ic_rvalid |-> (out_q != '0));
   a_tag_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
      resp_keep |-> !tag_empty);
   a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      accept |-> !tag_full);
   a_tag_tracks_out: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RUN) |-> (CW'(tag_count) == out_q));
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_keep && fifo_full) |-> id_pop);
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: the bench plays PC register, I-cache and decode, and
// compares every cycle against a queue-based reference of the fetch pipeline.
module tb_ifu_fetch_ctrl;

   localparam int unsigned DEP = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        fetch_adv, ic_req, ic_gnt, ic_rvalid, id_valid, id_ready, flush;
   logic [31:0] ic_addr, ic_rdata, id_inst, id_pc;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   ifu_fetch_ctrl #(
      .PC_W     (32),
      .INST_W   (32),
      .FIFO_DEP (DEP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_pc  (fetch_pc),
      .fetch_adv (fetch_adv),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_gnt    (ic_gnt),
      .ic_rvalid (ic_rvalid),
      .ic_rdata  (ic_rdata),
      .id_valid  (id_valid),
      .id_inst   (id_inst),
      .id_pc     (id_pc),
      .id_ready  (id_ready),
      .flush     (flush)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: mode 0 = waiting after reset, 1 = fetching, 2 = discarding killed responses.
   int          mode;
   int          drop;
   logic [31:0] infl[$];   // PCs of requests whose responses will be kept
   logic [63:0] outq[$];   // {pc, inst} visible to decode
   logic [31:0] pend[$];   // I-cache side: accepted, not yet answered
   logic [31:0] pc_reg;
   longint      m_fetch, m_stall;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      mode = 0; drop = 0; pc_reg = 32'h0; m_fetch = 0; m_stall = 0;
      infl.delete(); outq.delete(); pend.delete();
   endtask

   // Called at a negedge: drive one cycle, check, advance the reference, wait for the next negedge.
   task automatic cycle(input int pg, input int pr, input int pv, input int pf);
      logic        exp_req, acc, pop;
      logic [31:0] tag_pc;
      flush     = ($urandom_range(99) < pf);
      id_ready  = ($urandom_range(99) < pr);
      ic_gnt    = ($urandom_range(99) < pg);
      ic_rvalid = (pend.size() > 0) && ($urandom_range(99) < pv);
      ic_rdata  = $urandom;
      fetch_pc  = pc_reg;
      #1;
      exp_req = (mode == 1) && !flush && ((infl.size() + outq.size()) < DEP);
      acc     = exp_req && ic_gnt;
      pop     = (outq.size() > 0) && id_ready;
      check("ic_req", ic_req, exp_req);
      check("ic_addr", ic_addr, fetch_pc);
      check("fetch_adv", fetch_adv, acc);
      check("id_valid", id_valid, outq.size() > 0);
      if (outq.size() > 0) begin
         check("id_pc", id_pc, outq[0][63:32]);
         check("id_inst", id_inst, outq[0][31:0]);
      end
`ifdef IFU_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_fetch);
      check("perf_stall", perf_stall_cnt, m_stall);
      if (acc) m_fetch++;
      if (mode == 1 && !acc) m_stall++;
`endif
      // I-cache bookkeeping.
      if (ic_rvalid) void'(pend.pop_front());
      if (acc) pend.push_back(fetch_pc);
      // Fetch pipeline.
      if (mode == 0) begin
         mode = 1;
      end else if (flush) begin
         infl.delete();
         outq.delete();
         drop = pend.size();
         mode = (drop > 0) ? 2 : 1;
      end else if (mode == 1) begin
         if (pop) void'(outq.pop_front());
         if (ic_rvalid) begin
            tag_pc = infl.pop_front();
            outq.push_back({tag_pc, ic_rdata});
         end
         if (acc) infl.push_back(fetch_pc);
      end else begin
         if (ic_rvalid) drop--;
         if (drop == 0) mode = 1;
      end
      // PC register.
      if (flush) pc_reg = {$urandom_range(32'h3fff_ffff), 2'b00};
      else if (acc) pc_reg = pc_reg + 32'd4;
      @(negedge clk);
   endtask

   task automatic mid_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ic_req", ic_req, 1'b0);
      check("rst_fetch_adv", fetch_adv, 1'b0);
      check("rst_id_valid", id_valid, 1'b0);
      model_clear();
      flush = 1'b0; ic_gnt = 1'b0; ic_rvalid = 1'b0; id_ready = 1'b0; fetch_pc = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Phase table: grant %, ready %, response %, flush %, cycles.
   localparam int NPH = 8;
   int ph_g[NPH] = '{100, 100, 100,   0, 70, 100, 50, 90};
   int ph_r[NPH] = '{100,   0, 100, 100, 60, 100, 30, 80};
   int ph_v[NPH] = '{100, 100, 100, 100, 50,  30, 80, 60};
   int ph_f[NPH] = '{  0,   0,   0,   0, 10,  20,  5, 15};
   int ph_n[NPH] = '{ 40,  20,  10,   5, 400, 300, 300, 300};

   initial begin
      model_clear();
      rst_n = 1'b0;
      flush = 1'b0; ic_gnt = 1'b0; ic_rvalid = 1'b0; id_ready = 1'b0;
      fetch_pc = 32'h0; ic_rdata = 32'h0;
      @(negedge clk);
      #1;
      check("reset_ic_req", ic_req, 1'b0);
      check("reset_id_valid", id_valid, 1'b0);
      check("reset_fetch_adv", fetch_adv, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int rep = 0; rep < 3; rep++) begin
         for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_n[p]; c++) cycle(ph_g[p], ph_r[p], ph_v[p], ph_f[p]);
         end
         // Fill the pipe (decode stalled, slow responses) before resetting mid-operation.
         for (int c = 0; c < 6; c++) cycle(100, 0, 40, 0);
         mid_reset();
      end
      for (int c = 0; c < 20; c++) cycle(100, 100, 100, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
